// File: rtl/plusarg_config_sequencer_if.sv
// Config-register write channel: valid/ready handshake carrying one address/data word.
interface plusarg_config_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [ADDR_W-1:0] cfg_addr;
   logic [31:0]       cfg_data;

   modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
   modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/plusarg_config_sequencer.sv
// Snapshots plusarg_reader outputs after a settle interval and replays each enabled
// word as one write on the config-register bus; reload re-runs the sequence.
module plusarg_config_lane #(
   parameter int                ADDR_W = 8,
   parameter logic [ADDR_W-1:0] ADDR   = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              capture,
   input  logic [31:0]       value_in,
   input  logic              enable_in,
   output logic [31:0]       value,
   output logic              enable,
   output logic [ADDR_W-1:0] addr
);
   assign addr = ADDR;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         value  <= '0;
         enable <= 1'b0;
      end else if (capture) begin
         value  <= value_in;
         enable <= enable_in;
      end
   end
endmodule

module plusarg_config_sequencer #(
   parameter  int NUM_ARGS      = 4,
   parameter  int ADDR_W        = 8,
   parameter  int BASE_ADDR     = 0,
   parameter  int ADDR_STRIDE   = 1,
   parameter  int SETTLE_CYCLES = 4,
   localparam int CNT_W         = $clog2(NUM_ARGS + 1)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NUM_ARGS*32-1:0]   arg_values,
   input  logic [NUM_ARGS-1:0]      arg_enable,
   input  logic                     reload,
   plusarg_config_sequencer_if.master cfg,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         write_count
);
   localparam int IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_ARGS - 1);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   typedef enum logic [1:0] {SETTLE, CAPTURE, SEND, DONE} state_t;

   state_t                         state;
   logic [SET_W-1:0]               settle_cnt;
   logic [IDX_W-1:0]               index;
   logic                           reload_pend;
   logic                           capture;
   logic [NUM_ARGS-1:0][31:0]      lane_val;
   logic [NUM_ARGS-1:0]            lane_en;
   logic [NUM_ARGS-1:0][ADDR_W-1:0] lane_addr;
   logic [IDX_W-1:0]               next_idx;
   logic                           cur_en;
   logic                           step;

   assign capture = (state == CAPTURE);

   // Each lane owns its shadow word and a constant, wrap-truncated address.
   for (genvar i = 0; i < NUM_ARGS; i++) begin : g_lane
      plusarg_config_lane #(
         .ADDR_W (ADDR_W),
         .ADDR   (ADDR_W'(BASE_ADDR + i * ADDR_STRIDE))
      ) u_lane (
         .clock     (clock),
         .reset_n   (reset_n),
         .capture   (capture),
         .value_in  (arg_values[32*i +: 32]),
         .enable_in (arg_enable[i]),
         .value     (lane_val[i]),
         .enable    (lane_en[i]),
         .addr      (lane_addr[i])
      );
   end

   assign next_idx = index + 1'b1;
   assign cur_en   = lane_en[index];
   // A disabled slot never waits on cfg_ready; an enabled one waits for the handshake.
   assign step     = !cur_en || cfg.cfg_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= SETTLE;
         settle_cnt    <= '0;
         index         <= '0;
         reload_pend   <= 1'b0;
         write_count   <= '0;
         cfg.cfg_valid <= 1'b0;
         cfg.cfg_addr  <= '0;
         cfg.cfg_data  <= '0;
         busy          <= 1'b1;
         done          <= 1'b0;
      end else begin
         if (reload && state != DONE) reload_pend <= 1'b1;
         case (state)
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  state      <= CAPTURE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            CAPTURE: begin
               // Lanes latch this same edge, so the first slot is presented from the live inputs.
               index         <= '0;
               write_count   <= '0;
               cfg.cfg_valid <= arg_enable[0];
               cfg.cfg_addr  <= lane_addr[0];
               cfg.cfg_data  <= arg_values[31:0];
               state         <= SEND;
            end
            SEND: begin
               if (step) begin
                  if (cur_en) write_count <= write_count + 1'b1;
                  if (index == LAST_IDX) begin
                     cfg.cfg_valid <= 1'b0;
                     done          <= 1'b1;
                     busy          <= 1'b0;
                     state         <= DONE;
                  end else begin
                     index         <= next_idx;
                     cfg.cfg_valid <= lane_en[next_idx];
                     cfg.cfg_addr  <= lane_addr[next_idx];
                     cfg.cfg_data  <= lane_val[next_idx];
                  end
               end
            end
            DONE: begin
               cfg.cfg_valid <= 1'b0;
               if (reload || reload_pend) begin
                  state       <= SETTLE;
                  settle_cnt  <= '0;
                  done        <= 1'b0;
                  busy        <= 1'b1;
                  write_count <= '0;
                  reload_pend <= 1'b0;
               end
            end
            default: state <= SETTLE;
         endcase
      end
   end
endmodule
